// File: rtl/regfile_sb_if.sv
// Register-file bus: read ports, writeback, claim/flush scoreboard and debug view.
// The master drives indices, data and requests; the slave returns read data, busy flags and claim_ack.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
);
  logic [NREAD*ADDR_W-1:0] rd_addr;
  logic [NREAD*DATA_W-1:0] rd_data;
  logic [NREAD-1:0]        rd_busy;
  logic                    we;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wd;
  logic                    claim_en;
  logic [ADDR_W-1:0]       claim_addr;
  logic                    claim_ack;
  logic                    flush;
  logic [ADDR_W:0]         pend_cnt;
  logic [ADDR_W-1:0]       dbg_addr;
  logic [DATA_W-1:0]       dbg_data;

  modport master (
    output rd_addr, we, wr_addr, wd, claim_en, claim_addr, flush, dbg_addr,
    input  rd_data, rd_busy, claim_ack, pend_cnt, dbg_data
  );

  modport slave (
    input  rd_addr, we, wr_addr, wd, claim_en, claim_addr, flush, dbg_addr,
    output rd_data, rd_busy, claim_ack, pend_cnt, dbg_data
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass and a per-register pending scoreboard.
// Reads are zero-latency; a claim on a pending register is refused (WAW stall) unless released the same cycle.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input logic         clk_i,
  input logic         rst_ni,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_zero;
  logic              claim_ack;
  logic              release_hit;

  assign wr_zero     = ZR && (bus.wr_addr == '0);
  assign claim_ack   = bus.claim_en && !bus.flush && !(ZR && (bus.claim_addr == '0)) &&
                       (!pend_q[bus.claim_addr] || (bus.we && (bus.wr_addr == bus.claim_addr)));
  assign release_hit = bus.we && pend_q[bus.wr_addr] && !wr_zero;

  // Release is applied before claim so a same-address claim+writeback leaves the entry owned.
  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (bus.flush) begin
      pend_d = '0;
      cnt_d  = '0;
    end else begin
      if (bus.we) pend_d[bus.wr_addr] = 1'b0;
      if (claim_ack) pend_d[bus.claim_addr] = 1'b1;
      cnt_d = cnt_q + CW'(claim_ack) - CW'(release_hit);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (bus.we && !wr_zero) mem_q[bus.wr_addr] <= bus.wd;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic              zero;
    assign ra   = bus.rd_addr[g*ADDR_W +: ADDR_W];
    assign hit  = bus.we && (bus.wr_addr == ra);
    assign zero = ZR && (ra == '0);
    assign bus.rd_data[g*DATA_W +: DATA_W] = zero ? '0 : (hit ? bus.wd : mem_q[ra]);
    assign bus.rd_busy[g] = !zero && pend_q[ra] && !hit;
  end

  assign bus.dbg_data  = (ZR && (bus.dbg_addr == '0)) ? '0 : mem_q[bus.dbg_addr];
  assign bus.claim_ack = claim_ack;
  assign bus.pend_cnt  = cnt_q;
endmodule
